// File: rtl/tdc_spi_slave.sv
// SPI mode-0 slave (MSB first) with every pin oversampled in the clk domain.
// Optional byte counter output enabled by `define TDC_SPI_SLAVE_BYTECNT_EN.
module tdc_spi_slave #(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sck,
   input  logic                  mosi,
   input  logic                  cs,
   output logic                  miso,
   output logic                  miso_oe,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  tx_load,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  new_data,
   output logic                  busy,
   output logic                  abort
`ifdef TDC_SPI_SLAVE_BYTECNT_EN
   ,
   output logic [7:0]            byte_cnt
`endif
);

   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES:0]   flush;
   logic                   sck_s;
   logic                   mosi_s;
   logic                   cs_s;
   logic                   sck_prev;
   logic                   cs_prev;
   logic                   armed;
   logic                   sck_rise;
   logic                   sck_fall;
   logic                   cs_rise;
   logic                   cs_fall;
   logic                   mosi_bit;

   assign sck_s  = sck_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];

   // Edge flags are registered once more, with mosi delayed alongside so the
   // sampled data bit stays aligned with its sck rise.
   // A frame may only start after cs has been seen high through a flushed
   // synchronizer, so a cs still low after a reset never opens a frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync  <= '0;
         mosi_sync <= '0;
         cs_sync   <= '1;
         flush     <= '0;
         sck_prev  <= 1'b0;
         cs_prev   <= 1'b1;
         armed     <= 1'b0;
         sck_rise  <= 1'b0;
         sck_fall  <= 1'b0;
         cs_rise   <= 1'b0;
         cs_fall   <= 1'b0;
         mosi_bit  <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
         flush     <= {flush[SYNC_STAGES-1:0], 1'b1};
         sck_prev  <= sck_s;
         cs_prev   <= cs_s;
         armed     <= armed | (flush[SYNC_STAGES] & cs_s & cs_prev);
         sck_rise  <= sck_s & ~sck_prev;
         sck_fall  <= ~sck_s & sck_prev;
         cs_rise   <= cs_s & ~cs_prev;
         cs_fall   <= ~cs_s & cs_prev & armed;
         mosi_bit  <= mosi_s;
      end
   end

   state_t                state_q;
   state_t                state_d;
   logic [DATA_WIDTH-1:0] tx_q;
   logic [DATA_WIDTH-1:0] tx_d;
   logic [DATA_WIDTH-1:0] rx_q;
   logic [DATA_WIDTH-1:0] rx_d;
   logic [DATA_WIDTH-1:0] rx_next;
   logic [DATA_WIDTH-1:0] dout_d;
   logic [CW-1:0]         cnt_q;
   logic [CW-1:0]         cnt_d;
   logic                  miso_d;
   logic                  oe_d;
   logic                  nd_d;
   logic                  load_d;
   logic                  abort_d;
`ifdef TDC_SPI_SLAVE_BYTECNT_EN
   logic [7:0]            bc_q;
   logic [7:0]            bc_d;
`endif

   assign rx_next = (rx_q << 1) | DATA_WIDTH'(mosi_bit);
   assign busy    = (state_q == SHIFT);

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      cnt_d   = cnt_q;
      miso_d  = miso;
      oe_d    = miso_oe;
      dout_d  = data_out;
      nd_d    = 1'b0;
      load_d  = 1'b0;
      abort_d = 1'b0;
`ifdef TDC_SPI_SLAVE_BYTECNT_EN
      bc_d    = bc_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            miso_d = 1'b0;
            oe_d   = 1'b0;
            if (cs_fall) begin
               tx_d    = data_in;
               miso_d  = data_in[DATA_WIDTH-1];
               load_d  = 1'b1;
               oe_d    = 1'b1;
               state_d = SHIFT;
`ifdef TDC_SPI_SLAVE_BYTECNT_EN
               bc_d    = 8'd0;
`endif
            end
         end
         SHIFT: begin
            // cs rise wins over any sck edge flagged in the same cycle.
            if (cs_rise) begin
               state_d = IDLE;
               oe_d    = 1'b0;
               miso_d  = 1'b0;
               cnt_d   = '0;
               abort_d = (cnt_q != '0);
            end else if (sck_rise) begin
               rx_d  = rx_next;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                  dout_d = rx_next;
                  nd_d   = 1'b1;
`ifdef TDC_SPI_SLAVE_BYTECNT_EN
                  if (bc_q != 8'hFF) begin
                     bc_d = bc_q + 8'd1;
                  end
`endif
               end
            end else if (sck_fall) begin
               if (cnt_q != '0) begin
                  tx_d   = tx_q << 1;
                  miso_d = tx_d[DATA_WIDTH-1];
               end else begin
                  tx_d   = data_in;
                  miso_d = data_in[DATA_WIDTH-1];
                  load_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         tx_q     <= '0;
         rx_q     <= '0;
         cnt_q    <= '0;
         miso     <= 1'b0;
         miso_oe  <= 1'b0;
         data_out <= '0;
         new_data <= 1'b0;
         tx_load  <= 1'b0;
         abort    <= 1'b0;
`ifdef TDC_SPI_SLAVE_BYTECNT_EN
         bc_q     <= 8'd0;
`endif
      end else begin
         state_q  <= state_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         cnt_q    <= cnt_d;
         miso     <= miso_d;
         miso_oe  <= oe_d;
         data_out <= dout_d;
         new_data <= nd_d;
         tx_load  <= load_d;
         abort    <= abort_d;
`ifdef TDC_SPI_SLAVE_BYTECNT_EN
         bc_q     <= bc_d;
`endif
      end
   end

`ifdef TDC_SPI_SLAVE_BYTECNT_EN
   assign byte_cnt = bc_q;
`endif

endmodule

// File: tb/tb_tdc_spi_slave.sv
// Bench for tdc_spi_slave: an SPI master model drives directed and random
// frames; received bytes, pulses and latency are compared with a reference model.
module tb_tdc_spi_slave;

   localparam int SYNC_STAGES = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sck = 1'b0;
   logic       mosi = 1'b0;
   logic       cs = 1'b1;
   logic       miso;
   logic       miso_oe;
   logic [7:0] data_in = 8'h00;
   logic       tx_load;
   logic [7:0] data_out;
   logic       new_data;
   logic       busy;
   logic       abort;
`ifdef TDC_SPI_SLAVE_BYTECNT_EN
   logic [7:0] byte_cnt;
`endif

   tdc_spi_slave #(.SYNC_STAGES(SYNC_STAGES), .DATA_WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .sck      (sck),
      .mosi     (mosi),
      .cs       (cs),
      .miso     (miso),
      .miso_oe  (miso_oe),
      .data_in  (data_in),
      .tx_load  (tx_load),
      .data_out (data_out),
      .new_data (new_data),
      .busy     (busy),
      .abort    (abort)
`ifdef TDC_SPI_SLAVE_BYTECNT_EN
      ,
      .byte_cnt (byte_cnt)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // counters and queues fed by the monitor
   int         checks = 0;
   int         errors = 0;
   int         nd_cnt = 0;
   int         load_cnt = 0;
   int         abort_cnt = 0;
   int         busy_cyc = 0;
   int         oe_cyc = 0;
   int         nd_cyc = 0;
   int         rise_e0 = 0;
   logic [7:0] plan[$];
   logic [7:0] exp_q[$];
   logic [7:0] nd_q[$];
   logic [7:0] fb_tx[4];
   logic [7:0] fb_miso[4];
   logic [7:0] last_rx = 8'h00;

   // data_in always presents the next planned byte; each load consumes one
   always @(negedge clk) begin
      if (new_data) begin
         nd_cnt++;
         nd_cyc = cyc;
         nd_q.push_back(data_out);
      end
      if (tx_load) begin
         load_cnt++;
         if (plan.size() > 0) void'(plan.pop_front());
      end
      if (abort) abort_cnt++;
      if (busy) busy_cyc++;
      if (miso_oe) oe_cyc++;
      data_in = (plan.size() > 0) ? plan[0] : 8'h00;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // driver tasks (called on a negedge, return on a negedge)
   task automatic half();
      repeat ($urandom_range(4, 6)) @(negedge clk);
   endtask

   task automatic cs_fall();
      cs = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic cs_up();
      cs = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = tx[7-i];
         half();
         rx = {rx[6:0], miso};
         sck = 1'b1;
         if (i == 7) rise_e0 = cyc + 1;
         half();
         sck = 1'b0;
      end
      half();
   endtask

   task automatic toggle16();
      for (int i = 0; i < 16; i++) begin
         half();
         sck = ~sck;
      end
      half();
   endtask

   // full frame of n bytes using fb_tx (mosi) and fb_miso (slave data)
   task automatic send_frame(input string name, input int n);
      logic [7:0] rx;
      int nd0, ld0, ab0;
      for (int k = 0; k < n; k++) plan.push_back(fb_miso[k]);
      plan.push_back(8'($urandom));
      exp_q.delete();
      for (int k = 0; k < n; k++) exp_q.push_back(fb_tx[k]);
      nd_q.delete();
      nd0 = nd_cnt; ld0 = load_cnt; ab0 = abort_cnt;
      cs_fall();
      check({name, " busy_in_frame"}, busy, 1);
      check({name, " oe_in_frame"}, miso_oe, 1);
      check({name, " first_miso_bit"}, miso, fb_miso[0][7]);
      for (int k = 0; k < n; k++) begin
         xfer(fb_tx[k], 8, rx);
         check($sformatf("%s master_rx[%0d]", name, k), rx, fb_miso[k]);
         check($sformatf("%s latency[%0d]", name, k), nd_cyc - rise_e0, SYNC_STAGES + 1);
      end
      cs_up();
      check({name, " new_data_count"}, nd_cnt - nd0, n);
      check({name, " tx_load_count"}, load_cnt - ld0, n + 1);
      check({name, " abort_count"}, abort_cnt - ab0, 0);
      check({name, " nd_q_size"}, nd_q.size(), exp_q.size());
      while (nd_q.size() > 0 && exp_q.size() > 0)
         check({name, " new_data_byte"}, nd_q.pop_front(), exp_q.pop_front());
      last_rx = fb_tx[n-1];
      check({name, " data_out"}, data_out, last_rx);
      check({name, " busy_after"}, busy, 0);
      check({name, " oe_after"}, miso_oe, 0);
`ifdef TDC_SPI_SLAVE_BYTECNT_EN
      check({name, " byte_cnt"}, byte_cnt, n);
`endif
   endtask

   initial begin : stim
      logic [7:0] rx;
      int nd0, ld0, ab0, bz0, oe0, n;

      // reset values
      repeat (3) @(negedge clk);
      check("rst miso", miso, 0);
      check("rst miso_oe", miso_oe, 0);
      check("rst data_out", data_out, 0);
      check("rst new_data", new_data, 0);
      check("rst tx_load", tx_load, 0);
      check("rst busy", busy, 0);
      check("rst abort", abort, 0);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      // single byte
      fb_tx[0] = 8'h3C; fb_miso[0] = 8'hA5;
      send_frame("single", 1);

      // three-byte frame
      fb_tx[0] = 8'h01; fb_tx[1] = 8'h02; fb_tx[2] = 8'h03;
      fb_miso[0] = 8'h11; fb_miso[1] = 8'h22; fb_miso[2] = 8'h33;
      send_frame("three", 3);

      // random frames
      for (int f = 0; f < 4; f++) begin
         n = $urandom_range(1, 4);
         for (int k = 0; k < 4; k++) begin
            fb_tx[k] = 8'($urandom);
            fb_miso[k] = 8'($urandom);
         end
         send_frame($sformatf("rand%0d", f), n);
      end

      // abort after 5 sck rises
      plan.push_back(8'($urandom));
      nd0 = nd_cnt; ld0 = load_cnt; ab0 = abort_cnt;
      cs_fall();
      xfer(8'($urandom), 5, rx);
      cs_up();
      check("abort count", abort_cnt - ab0, 1);
      check("abort new_data", nd_cnt - nd0, 0);
      check("abort tx_load", load_cnt - ld0, 1);
      check("abort data_out", data_out, last_rx);
      check("abort miso_oe", miso_oe, 0);
      check("abort busy", busy, 0);
`ifdef TDC_SPI_SLAVE_BYTECNT_EN
      check("abort byte_cnt", byte_cnt, 0);
`endif
      fb_tx[0] = 8'hFF; fb_miso[0] = 8'($urandom);
      send_frame("after_abort", 1);

      // reset for one cycle after 3 bits
      plan.push_back(8'($urandom));
      cs_fall();
      xfer(8'($urandom), 3, rx);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst miso", miso, 0);
      check("midrst miso_oe", miso_oe, 0);
      check("midrst data_out", data_out, 0);
      check("midrst new_data", new_data, 0);
      check("midrst tx_load", tx_load, 0);
      check("midrst busy", busy, 0);
      check("midrst abort", abort, 0);
`ifdef TDC_SPI_SLAVE_BYTECNT_EN
      check("midrst byte_cnt", byte_cnt, 0);
`endif
      nd0 = nd_cnt; ld0 = load_cnt; bz0 = busy_cyc;
      toggle16();
      check("midrst no_new_data", nd_cnt - nd0, 0);
      check("midrst no_tx_load", load_cnt - ld0, 0);
      check("midrst no_busy", busy_cyc - bz0, 0);
      cs_up();
      fb_tx[0] = 8'($urandom); fb_miso[0] = 8'($urandom);
      send_frame("after_rst", 1);

      // sck toggling with cs high
      nd0 = nd_cnt; ld0 = load_cnt; bz0 = busy_cyc; oe0 = oe_cyc;
      toggle16();
      check("ignored new_data", nd_cnt - nd0, 0);
      check("ignored tx_load", load_cnt - ld0, 0);
      check("ignored busy", busy_cyc - bz0, 0);
      check("ignored miso_oe", oe_cyc - oe0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
